// File: rtl/adc_acc_pkg.sv
// rtl/adc_acc_pkg.sv - shared types and result-word layout for the gated ADC accumulator
package adc_acc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } ch_state_e;

  // Result word is {overflow, overrun, count, sum}, MSB first
  function automatic int count_lsb(input int sum_w);
    return sum_w;
  endfunction

  function automatic int overrun_bit(input int sum_w, input int cnt_w);
    return sum_w + cnt_w;
  endfunction

  function automatic int overflow_bit(input int sum_w, input int cnt_w);
    return sum_w + cnt_w + 1;
  endfunction

endpackage

// File: rtl/adc_acc_channel.sv
// rtl/adc_acc_channel.sv - one channel: gate FSM, saturating accumulator, one-deep result holder
module adc_acc_channel
  import adc_acc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SUM_W    = 24,
  parameter int CNT_W    = 14,
  parameter int SIGNED   = 0,
  parameter int RESULT_W = SUM_W + CNT_W + 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_ready,
  input  logic                adc_gate,
  input  logic                grant,
  output logic                pending,
  output logic [RESULT_W-1:0] held
);

  localparam int CNT_LSB = count_lsb(SUM_W);
  localparam int OVR_BIT = overrun_bit(SUM_W, CNT_W);
  localparam int OVF_BIT = overflow_bit(SUM_W, CNT_W);

  ch_state_e        state, state_nxt;
  logic             open_win, accum_win, close_win, take;
  logic [SUM_W-1:0] sum, sample_ext, sum_sat;
  logic [SUM_W:0]   sum_wide;
  logic             add_ovf;
  logic [CNT_W-1:0] count;
  logic             cnt_full;
  logic             ovf;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: the gate alone opens and closes the window
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (adc_gate)  state_nxt = ACCUM;
      ACCUM:   if (!adc_gate) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: window open, continue and close strobes
  always_comb begin
    open_win  = (state == IDLE)  && adc_gate;
    accum_win = (state == ACCUM) && adc_gate;
    close_win = (state == ACCUM) && !adc_gate;
    take      = adc_ready && adc_gate;
  end

  // Extend the sample and form the saturated sum of sum + sample
  always_comb begin
    sample_ext = '0;
    sum_wide   = '0;
    add_ovf    = 1'b0;
    sum_sat    = '0;
    if (SIGNED != 0) begin
      sample_ext = SUM_W'($signed(adc_data));
      sum_wide   = {sum[SUM_W-1], sum} + {sample_ext[SUM_W-1], sample_ext};
      add_ovf    = sum_wide[SUM_W] ^ sum_wide[SUM_W-1];
      if (add_ovf) sum_sat = sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
      else         sum_sat = sum_wide[SUM_W-1:0];
    end else begin
      sample_ext = SUM_W'(adc_data);
      sum_wide   = {1'b0, sum} + {1'b0, sample_ext};
      add_ovf    = sum_wide[SUM_W];
      sum_sat    = add_ovf ? '1 : sum_wide[SUM_W-1:0];
    end
    cnt_full = &count;
  end

  // Running window accumulator; the first window cycle restarts from the sample or zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (open_win) begin
      sum   <= take ? sample_ext : '0;
      count <= take ? CNT_W'(1) : '0;
      ovf   <= 1'b0;
    end else if (accum_win && take) begin
      sum   <= sum_sat;
      count <= cnt_full ? count : count + CNT_W'(1);
      ovf   <= ovf | add_ovf | cnt_full;
    end
  end

  // Holding register: a close while still pending overwrites and marks overrun;
  // a grant in the same edge has already taken the old value, so no overrun then
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held    <= '0;
      pending <= 1'b0;
    end else if (close_win) begin
      held[SUM_W-1:0]          <= sum;
      held[CNT_LSB +: CNT_W]   <= count;
      held[OVR_BIT]            <= pending & ~grant;
      held[OVF_BIT]            <= ovf;
      pending                  <= 1'b1;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_gated_accumulator.sv
// rtl/adc_gated_accumulator.sv - multi-channel gated ADC accumulator with round-robin result port
module adc_gated_accumulator
  import adc_acc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int SUM_W    = 24,
  parameter int CNT_W    = 14,
  parameter int SIGNED   = 0,
  parameter int RESULT_W = SUM_W + CNT_W + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [NUM_CH-1:0]        adc_ready,
  input  logic [NUM_CH-1:0]        adc_gate,
  input  logic [7:0]               counter_id,
  output logic [RESULT_W-1:0]      result,
  output logic                     result_ready,
  input  logic                     result_ack,
  output logic [7:0]               counter_id_out
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   pending, grant;
  logic [RESULT_W-1:0] held [NUM_CH];
  logic [RESULT_W-1:0] sel_held;
  logic [PTR_W-1:0]    ptr, grant_idx;
  logic                grant_vld;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_acc_channel #(
      .DATA_W  (DATA_W),
      .SUM_W   (SUM_W),
      .CNT_W   (CNT_W),
      .SIGNED  (SIGNED),
      .RESULT_W(RESULT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .adc_data (adc_data[k*DATA_W +: DATA_W]),
      .adc_ready(adc_ready[k]),
      .adc_gate (adc_gate[k]),
      .grant    (grant[k]),
      .pending  (pending[k]),
      .held     (held[k])
    );
  end

  // Round-robin pick: first pending at or above the pointer, else first pending below it
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!result_ready && !grant_vld && pending[k] && (k >= int'(ptr))) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!result_ready && !grant_vld && pending[k]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end

  // One-hot grant and the held word it selects
  always_comb begin
    grant    = '0;
    sel_held = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      grant[k] = grant_vld && (int'(grant_idx) == k);
      if (grant[k]) sel_held = held[k];
    end
  end

  // Output register; ready falls for a cycle after each transfer before the next grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result         <= '0;
      result_ready   <= 1'b0;
      counter_id_out <= '0;
      ptr            <= '0;
    end else if (grant_vld) begin
      result         <= sel_held;
      result_ready   <= 1'b1;
      counter_id_out <= counter_id + 8'(grant_idx);
      ptr            <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + PTR_W'(1);
    end else if (result_ready && result_ack) begin
      result_ready   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_gated_accumulator.sv
// tb/tb_adc_gated_accumulator.sv - self-checking bench for adc_gated_accumulator
module tb_adc_gated_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] adc_data = '0;
  logic [3:0]  adc_ready = '0, adc_gate = '0;
  logic [7:0]  counter_id = 8'd14;
  logic [39:0] result;
  logic        result_ready;
  logic        result_ack = 1'b1;
  logic [7:0]  counter_id_out;

  logic        a_gate = 1'b0, s_ready = 1'b0, u_ready = 1'b0;
  logic [15:0] s_data = '0, u_data = '0;
  logic [39:0] s_result;
  logic        s_rdy;
  logic [7:0]  s_id;
  logic [21:0] u_result;
  logic        u_rdy;
  logic [7:0]  u_id;

  adc_gated_accumulator dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_ready(adc_ready),
    .adc_gate(adc_gate), .counter_id(counter_id), .result(result),
    .result_ready(result_ready), .result_ack(result_ack), .counter_id_out(counter_id_out)
  );

  adc_gated_accumulator #(.NUM_CH(1), .SIGNED(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .adc_data(s_data), .adc_ready(s_ready),
    .adc_gate(a_gate), .counter_id(8'd0), .result(s_result),
    .result_ready(s_rdy), .result_ack(1'b1), .counter_id_out(s_id)
  );

  adc_gated_accumulator #(.NUM_CH(1), .SUM_W(16), .CNT_W(4)) dut_u (
    .clk(clk), .reset_n(reset_n), .adc_data(u_data), .adc_ready(u_ready),
    .adc_gate(a_gate), .counter_id(8'd0), .result(u_result),
    .result_ready(u_rdy), .result_ack(1'b1), .counter_id_out(u_id)
  );

  typedef struct {
    logic [39:0] res;
    logic [7:0]  id;
  } exp_t;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          nstb;
    int          len;
    logic [7:0]  cid;
    logic [23:0] esum;
    logic [13:0] ecnt;
    logic [7:0]  eid;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [39:0] mk(input logic ovf, input logic ovr,
                                     input logic [13:0] cnt, input logic [23:0] sum);
    return {ovf, ovr, cnt, sum};
  endfunction

  task automatic push(input logic [39:0] r, input logic [7:0] id);
    exp_t e;
    e.res = r;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gate the masked channels for len cycles, strobing the first nstb; strobe also in the fall cycle
  task automatic window(input logic [3:0] mask, input int nstb, input int len);
    for (int i = 0; i < len; i++) begin
      adc_gate  = mask;
      adc_ready = (i < nstb) ? mask : 4'b0;
      tick();
    end
    adc_gate  = 4'b0;
    adc_ready = mask;
    tick();
    adc_ready = 4'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (3) tick();
  endtask

  // Transfer monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && result_ready && result_ack) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got %h id %0d, required none", result, counter_id_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("counter_id_out", counter_id_out, e.id);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    logic seen, got_s, got_u;

    vt[0] = '{0, 16'd12,     5, 5,  8'd14,  24'd60,      14'd5, 8'd14};
    vt[1] = '{1, 16'hFFFF,   3, 4,  8'd14,  24'h02FFFD,  14'd3, 8'd15};
    vt[2] = '{2, 16'd5,      0, 10, 8'd14,  24'd0,       14'd0, 8'd16};
    vt[3] = '{3, 16'd1000,   7, 9,  8'd254, 24'd7000,    14'd7, 8'd1};
    vt[4] = '{1, 16'h8000,   1, 1,  8'd200, 24'h008000,  14'd1, 8'd201};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 0);
    check("reset_ready", result_ready, 0);
    check("reset_id", counter_id_out, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Simultaneous closes and round-robin order
    adc_data = {16'd4, 16'd3, 16'd2, 16'd1};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(mk(0, 0, 14'd1, 24'(k + 1)), 8'(14 + k));
      window(4'hF, 1, 2);
      drain();
    end
    push(mk(0, 0, 14'd1, 24'd3), 8'd16);
    window(4'b0100, 1, 2);
    drain();
    for (int k = 3; k < 7; k++) push(mk(0, 0, 14'd1, 24'((k % 4) + 1)), 8'(14 + (k % 4)));
    window(4'hF, 1, 2);
    drain();

    // Single-channel windows from the vector table
    for (int v = 0; v < 5; v++) begin
      counter_id = vt[v].cid;
      adc_data = '0;
      adc_data[vt[v].ch*16 +: 16] = vt[v].data;
      push(mk(0, 0, vt[v].ecnt, vt[v].esum), vt[v].eid);
      window(4'(1 << vt[v].ch), vt[v].nstb, vt[v].len);
      if (v == 0) begin
        @(negedge clk);
        check("latency_cycle1_ready", result_ready, 0);
        @(negedge clk);
        check("latency_cycle2_ready", result_ready, 1);
      end
      drain();
    end

    // Overrun with the consumer stalled
    counter_id = 8'd14;
    adc_data = 64'd1;
    result_ack = 1'b0;
    push(mk(0, 0, 14'd1, 24'd1), 8'd14);
    window(4'b0001, 1, 1);
    repeat (3) tick();
    window(4'b0001, 2, 2);
    repeat (2) tick();
    push(mk(0, 1, 14'd3, 24'd3), 8'd14);
    window(4'b0001, 3, 3);
    repeat (3) tick();
    @(negedge clk);
    check("stall_ready_held", result_ready, 1);
    check("stall_result_stable", result, mk(0, 0, 14'd1, 24'd1));
    tick();
    result_ack = 1'b1;
    drain();
    repeat (10) tick();

    // Signed sum and unsigned saturation on the single-channel instances
    s_data = 16'hFFFB;
    u_data = 16'hFFFF;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < ((w == 0) ? 3 : 17); i++) begin
        a_gate  = 1'b1;
        s_ready = 1'b1;
        u_ready = (w == 1) || (i < 2);
        tick();
      end
      a_gate = 1'b0;
      s_ready = 1'b0;
      u_ready = 1'b0;
      got_s = 1'b0;
      got_u = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (s_rdy) begin
          got_s = 1'b1;
          check("signed_result", s_result, (w == 0) ? mk(0, 0, 14'd3, 24'hFFFFF1)
                                                    : mk(0, 0, 14'd17, 24'hF78000));
        end
        if (u_rdy) begin
          got_u = 1'b1;
          check("unsigned_sat_result", u_result, (w == 0) ? {1'b1, 1'b0, 4'd2, 16'hFFFF}
                                                          : {1'b1, 1'b0, 4'hF, 16'd17});
        end
      end
      check("aux_result_seen", {got_s, got_u}, 2'b11);
      tick();
      s_data = 16'h8000;
      u_data = 16'd1;
    end

    // Asynchronous reset mid-window
    adc_data = {16'd9, 16'd9, 16'd9, 16'd7};
    adc_gate = 4'b0001;
    adc_ready = 4'b0001;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_result", result, 0);
    check("rst_mid_ready", result_ready, 0);
    check("rst_mid_id", counter_id_out, 0);
    adc_gate = '0;
    adc_ready = '0;
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_ready) seen = 1'b1;
    end
    check("rst_mid_no_result", seen, 0);
    tick();

    // Asynchronous reset while a result is presented and another is pending
    result_ack = 1'b0;
    window(4'b0011, 2, 2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (result_ready) seen = 1'b1;
    end
    check("rst_ready_before", seen, 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_ready_result", result, 0);
    check("rst_ready_ready", result_ready, 0);
    check("rst_ready_id", counter_id_out, 0);
    result_ack = 1'b1;
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_ready) seen = 1'b1;
    end
    check("rst_ready_no_result", seen, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
